// File: rtl/rule110_pkg.sv
// Shared definitions for the Rule 110 automaton: state encoding, rule table,
// seed pattern and the per-cell next-state function.
package rule110_pkg;

    localparam int unsigned MAX_CELLS = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Bit {l,c,r} of RULE is the next value of the centre cell
    localparam logic [7:0] RULE = 8'd110;

    // Seed: only cell[0] set; callers truncate to their array width
    function automatic logic [MAX_CELLS-1:0] seed_pattern();
        return MAX_CELLS'(1);
    endfunction

    function automatic logic cell_next(input logic l, input logic c, input logic r);
        return RULE[{l, c, r}];
    endfunction

endpackage

// File: rtl/rule110_prescaler.sv
// Free-run generation prescaler: counts 0..MAX_COUNT-1 while enabled and
// flags the terminal count so the automaton can advance on that edge.
module rule110_prescaler #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    localparam int unsigned CNT_W = (MAX_COUNT > 24'd1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 24'd1);

    logic [CNT_W-1:0] count;

    assign terminal_c = enable && (count == LAST);

    // Clear wins over enable so a dropped run discards the partial count
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rule110_automaton.sv
// Rule 110 cellular automaton on a ring of CELLS cells with serial load,
// single-step and prescaled free-run advance, and an 8-cell paged readout.
module rule110_automaton
    import rule110_pkg::*;
#(
    parameter int unsigned  CELLS     = 32,
    parameter logic [23:0]  MAX_COUNT = 24'd10_000_000,
    parameter int unsigned  GEN_W     = 16,
    localparam int unsigned PAGES     = CELLS / 8,
    localparam int unsigned PAGE_W    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_bit,
    input  logic              run,
    input  logic              step,
    input  logic [PAGE_W-1:0] page_sel,
    output logic [7:0]        cells_out,
    output logic [GEN_W-1:0]  generation,
    output logic              tick,
    output logic [1:0]        state
);

    state_t           fsm_state;
    logic [CELLS-1:0] cells;
    logic [CELLS-1:0] next_cells_c;
    logic [7:0]       window_c;
    logic             presc_en_c;
    logic             presc_done_c;

    assign state      = fsm_state;
    assign presc_en_c = run && !load_en;

    rule110_prescaler #(
        .MAX_COUNT(MAX_COUNT)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .clear     (!presc_en_c),
        .enable    (presc_en_c),
        .terminal_c(presc_done_c)
    );

    // Ring neighbourhood: left is i+1, right is i-1, both wrapping
    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        localparam int unsigned LEFT  = (i + 1) % CELLS;
        localparam int unsigned RIGHT = (i + CELLS - 1) % CELLS;
        assign next_cells_c[i] = cell_next(cells[LEFT], cells[i], cells[RIGHT]);
    end

    // Out-of-range pages match no iteration and read as zero
    always_comb begin
        window_c = '0;
        for (int p = 0; p < PAGES; p++) begin
            if (page_sel == PAGE_W'(p)) begin
                window_c = cells[8*p +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state  <= ST_IDLE;
            cells      <= CELLS'(seed_pattern());
            generation <= '0;
            tick       <= 1'b0;
            cells_out  <= '0;
        end else begin
            tick      <= 1'b0;
            cells_out <= window_c;
            if (load_en) begin
                fsm_state  <= ST_LOAD;
                cells      <= {cells[CELLS-2:0], load_bit};
                generation <= '0;
            end else if (run) begin
                fsm_state <= ST_RUN;
                if (presc_done_c) begin
                    cells      <= next_cells_c;
                    generation <= generation + GEN_W'(1);
                    tick       <= 1'b1;
                end
            end else begin
                fsm_state <= ST_IDLE;
                if (step) begin
                    cells      <= next_cells_c;
                    generation <= generation + GEN_W'(1);
                    tick       <= 1'b1;
                end
            end
        end
    end

endmodule
